// File: rtl/axi_rd_arbiter.sv
// Round-robin read arbiter sharing one AXI master AR/R channel between the
// ICache and DCache refill engines, one whole burst per grant.
module axi_rd_arbiter #(
    parameter int         BURST_LEN = 1,
    parameter logic [3:0] IC_ID     = 4'd0,
    parameter logic [3:0] DC_ID     = 4'd1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        ic_arvalid,
    output logic        ic_arready,
    input  logic [31:0] ic_araddr,
    output logic        ic_rvalid,
    input  logic        ic_rready,
    input  logic        dc_arvalid,
    output logic        dc_arready,
    input  logic [31:0] dc_araddr,
    output logic        dc_rvalid,
    input  logic        dc_rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [63:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic [3:0]  m_rid
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e      state_q, state_d;
    logic        grant_q, grant_d;          // 0 = ICache, 1 = DCache
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;

    // Beats are steered by the grant register alone, so the returned id is ignored.
    logic unused_rid;
    assign unused_rid = ^m_rid;

    assign m_araddr  = addr_q;
    assign m_arlen   = 8'(BURST_LEN);
    assign m_arsize  = 3'b011;
    assign m_arburst = 2'b01;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        m_arvalid    = 1'b0;
        m_arid       = '0;
        ic_arready   = 1'b0;
        dc_arready   = 1'b0;
        m_rready     = 1'b0;
        ic_rvalid    = 1'b0;
        dc_rvalid    = 1'b0;
        rdata        = '0;
        rresp        = '0;
        rlast        = 1'b0;

        case (state_q)
            IDLE: begin
                if (ic_arvalid || dc_arvalid) begin
                    // On a tie the requester that did not win last time goes first.
                    grant_d = dc_arvalid && (!ic_arvalid || !last_grant_q);
                    addr_d  = grant_d ? dc_araddr : ic_araddr;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_arvalid  = 1'b1;
                m_arid     = grant_q ? DC_ID : IC_ID;
                ic_arready = !grant_q && m_arready;
                dc_arready = grant_q && m_arready;
                if (m_arready) begin
                    state_d      = DATA;
                    last_grant_d = grant_q;
                end
            end
            DATA: begin
                m_rready  = grant_q ? dc_rready : ic_rready;
                ic_rvalid = !grant_q && m_rvalid;
                dc_rvalid = grant_q && m_rvalid;
                rdata     = m_rdata;
                rresp     = m_rresp;
                rlast     = m_rlast;
                if (m_rvalid && m_rready && m_rlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized scoreboard bench for axi_rd_arbiter: a transaction-level
// round-robin model predicts AR order and beat routing.
module tb_axi_rd_arbiter;

    localparam int         BL    = 1;
    localparam logic [3:0] IC_ID = 4'd0;
    localparam logic [3:0] DC_ID = 4'd1;

    logic        clock, rst_n;
    logic        ic_arvalid, ic_arready, ic_rvalid, ic_rready;
    logic        dc_arvalid, dc_arready, dc_rvalid, dc_rready;
    logic [31:0] ic_araddr, dc_araddr, m_araddr;
    logic [63:0] rdata, m_rdata;
    logic [1:0]  rresp, m_rresp, m_arburst;
    logic        rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [3:0]  m_arid, m_rid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;

    axi_rd_arbiter #(.BURST_LEN(BL), .IC_ID(IC_ID), .DC_ID(DC_ID)) dut (
        .clock(clock), .rst_n(rst_n),
        .ic_arvalid(ic_arvalid), .ic_arready(ic_arready), .ic_araddr(ic_araddr),
        .ic_rvalid(ic_rvalid), .ic_rready(ic_rready),
        .dc_arvalid(dc_arvalid), .dc_arready(dc_arready), .dc_araddr(dc_araddr),
        .dc_rvalid(dc_rvalid), .dc_rready(dc_rready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        to_dc;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  rid;
    } beat_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
    } ar_t;

    beat_t exp_r[$];
    beat_t slv_q[$];
    ar_t   exp_ar[$];
    int    vectors    = 0;
    int    miscompares = 0;

    // reference model state: outstanding requests and who won last
    bit [1:0]    pend;
    logic [31:0] paddr [2];
    int          last_g;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // slave: random AR ready, beats replayed from slv_q with random gaps
    initial begin : slave
        bit    arf, rf;
        int    sl_left;
        beat_t b;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rid = '0;
        sl_left = 0;
        forever begin
            @(negedge clock);
            arf = m_arvalid && m_arready;
            rf  = m_rvalid && m_rready;
            @(posedge clock); #1;
            if (!rst_n) begin
                sl_left = 0; slv_q.delete(); m_rvalid = 0; m_arready = 0;
                continue;
            end
            if (arf) sl_left = BL + 1;
            if (rf) begin
                void'(slv_q.pop_front());
                sl_left--;
            end
            m_arready = ($urandom % 3) != 0;
            if (!(m_rvalid && !rf)) begin
                if (sl_left > 0 && slv_q.size() > 0 && ($urandom % 4) != 0) begin
                    b = slv_q[0];
                    m_rvalid = 1; m_rdata = b.data; m_rresp = b.resp;
                    m_rlast = b.last; m_rid = b.rid;
                end else begin
                    m_rvalid = 0; m_rlast = 0; m_rdata = {$urandom, $urandom};
                end
            end
        end
    end

    initial begin : rready_drv
        ic_rready = 0; dc_rready = 0;
        forever begin
            @(posedge clock); #1;
            ic_rready = ($urandom % 4) != 0;
            dc_rready = ($urandom % 4) != 0;
        end
    end

    // monitor: pops scoreboard queues whenever the DUT presents a handshake
    initial begin : monitor
        bit          hold;
        logic [31:0] hold_addr;
        ar_t         a;
        beat_t       e;
        hold = 0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                hold = 0;
                continue;
            end
            if (ic_rvalid && dc_rvalid) chk("both_rvalid", 64'(dc_rvalid), 64'd0);
            if (hold) begin
                chk("ar_hold_valid", 64'(m_arvalid), 64'd1);
                chk("ar_hold_addr", 64'(m_araddr), 64'(hold_addr));
            end
            hold      = m_arvalid && !m_arready;
            hold_addr = m_araddr;
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 64'(exp_ar.size()), 64'd1);
                else begin
                    a = exp_ar.pop_front();
                    chk("arid", 64'(m_arid), 64'(a.id));
                    chk("araddr", 64'(m_araddr), 64'(a.addr));
                    chk("arlen", 64'(m_arlen), 64'(BL));
                    chk("arsize", 64'(m_arsize), 64'd3);
                    chk("arburst", 64'(m_arburst), 64'd1);
                    chk("arready_gnt", 64'(a.id == DC_ID ? dc_arready : ic_arready), 64'd1);
                    chk("arready_other", 64'(a.id == DC_ID ? ic_arready : dc_arready), 64'd0);
                end
            end
            if ((ic_rvalid && ic_rready) || (dc_rvalid && dc_rready)) begin
                if (exp_r.size() == 0) chk("r_unexpected", 64'(exp_r.size()), 64'd1);
                else begin
                    e = exp_r.pop_front();
                    chk("r_dest", 64'(dc_rvalid), 64'(e.to_dc));
                    chk("rdata", rdata, e.data);
                    chk("rresp", 64'(rresp), 64'(e.resp));
                    chk("rlast", 64'(rlast), 64'(e.last));
                end
            end
        end
    end

    // mode 0: random requests, 1: both with fixed addresses, 2: ICache only
    task automatic issue(input int mode, output int w);
        beat_t b;
        ar_t   a;
        if (mode == 1) begin
            pend = 2'b11; paddr[0] = 32'h8000_0000; paddr[1] = 32'h8000_1000;
        end else if (mode == 2) begin
            pend[0] = 1; paddr[0] = 32'h8000_0000;
        end else begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && ($urandom % 3) != 0) begin
                    pend[r] = 1;
                    paddr[r] = {$urandom} & 32'hFFFF_FFF0;
                end
            if (pend == 2'b00) begin
                pend[$urandom % 2] = 1'b1;
                paddr[0] = {$urandom} & 32'hFFFF_FFF0;
                paddr[1] = {$urandom} & 32'hFFFF_FFF0;
            end
        end
        ic_arvalid = pend[0]; ic_araddr = paddr[0];
        dc_arvalid = pend[1]; dc_araddr = paddr[1];
        w = (pend == 2'b11) ? ((last_g == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
        last_g = w;
        a.id = (w == 1) ? DC_ID : IC_ID;
        a.addr = paddr[w];
        exp_ar.push_back(a);
        for (int i = 0; i <= BL; i++) begin
            b.to_dc = (w == 1);
            b.data  = {$urandom, $urandom};
            b.resp  = 2'($urandom % 4);
            b.last  = (i == BL);
            b.rid   = 4'($urandom % 16);
            exp_r.push_back(b);
            slv_q.push_back(b);
        end
    endtask

    task automatic wait_ar(input int w);
        int n;
        @(posedge clock);
        @(negedge clock);
        chk("ar_latency", 64'(m_arvalid), 64'd1);
        n = 0;
        while (!(m_arvalid && m_arready) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("ar_timeout", 64'(m_arvalid && m_arready), 64'd1);
        @(posedge clock); #1;
        pend[w] = 0;
        if (w == 1) dc_arvalid = 0; else ic_arvalid = 0;
    endtask

    function automatic bit beat_fire(input int w);
        return (w == 1) ? (dc_rvalid && dc_rready) : (ic_rvalid && ic_rready);
    endfunction

    task automatic wait_beat(input int w, input bit need_last);
        int n;
        n = 0;
        @(negedge clock);
        while (!(beat_fire(w) && (!need_last || rlast)) && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) chk("r_timeout", 64'(beat_fire(w)), 64'd1);
        @(posedge clock); #1;
    endtask

    initial begin : stim
        int w;
        rst_n = 0; ic_arvalid = 0; dc_arvalid = 0; ic_araddr = '0; dc_araddr = '0;
        pend = 2'b00; paddr[0] = '0; paddr[1] = '0; last_g = 0;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_ic_arready", 64'(ic_arready), 64'd0);
        chk("rst_dc_arready", 64'(dc_arready), 64'd0);
        chk("rst_m_rready", 64'(m_rready), 64'd0);
        chk("rst_rvalid", 64'({ic_rvalid, dc_rvalid}), 64'd0);
        chk("rst_m_araddr", 64'(m_araddr), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_arlen", 64'(m_arlen), 64'(BL));
        chk("rst_arsize", 64'(m_arsize), 64'd3);
        chk("rst_arburst", 64'(m_arburst), 64'd1);
        @(negedge clock) rst_n = 1;
        @(posedge clock); #1;

        for (int r = 0; r < 60; r++) begin
            issue((r == 0) ? 1 : 0, w);
            wait_ar(w);
            wait_beat(w, 1'b1);
        end

        // reset after the first beat of a burst
        issue(0, w);
        wait_ar(w);
        wait_beat(w, 1'b0);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_m_rready", 64'(m_rready), 64'd0);
        chk("mid_rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("mid_rst_rvalid", 64'({ic_rvalid, dc_rvalid}), 64'd0);
        ic_arvalid = 0; dc_arvalid = 0;
        pend = 2'b00; last_g = 0;
        exp_r.delete(); exp_ar.delete();
        repeat (2) @(posedge clock);
        @(negedge clock) rst_n = 1;
        @(posedge clock); #1;

        issue(2, w);
        wait_ar(w);
        wait_beat(w, 1'b1);
        for (int r = 0; r < 10; r++) begin
            issue(0, w);
            wait_ar(w);
            wait_beat(w, 1'b1);
        end
        // drain whichever requester is still pending
        while (pend != 2'b00) begin
            issue(0, w);
            wait_ar(w);
            wait_beat(w, 1'b1);
        end
        repeat (3) @(posedge clock);
        chk("drain_ar", 64'(exp_ar.size()), 64'd0);
        chk("drain_r", 64'(exp_r.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-requester read arbiter that shares the single CPU AXI master read channel (AR/R) between the ICache refill engine and the DCache refill engine.
- Sits between the cache refill FSMs and the AXI master port that drives the AXI SRAM/DDR slave.
- Grants one whole burst at a time with round-robin priority.
- Drives fixed AXI attributes: INCR burst, 8-byte beats.

Parameters:
- BURST_LEN, 1, AXI arlen value driven on every request (beats = BURST_LEN+1).
- IC_ID, 0, arid used for ICache bursts.
- DC_ID, 1, arid used for DCache bursts.

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ic_arvalid  in  1  ICache read request valid
ic_arready  out  1  ICache request accepted
ic_araddr  in  32  ICache burst start address
ic_rvalid  out  1  read beat valid for ICache
ic_rready  in  1  ICache can take beat
dc_arvalid  in  1  DCache read request valid
dc_arready  out  1  DCache request accepted
dc_araddr  in  32  DCache burst start address
dc_rvalid  out  1  read beat valid for DCache
dc_rready  in  1  DCache can take beat
rdata  out  64  beat data, shared by both requesters
rresp  out  2  beat response, shared
rlast  out  1  last beat of burst, shared
m_arvalid  out  1  master AR valid
m_arready  in  1  slave AR ready
m_araddr  out  32  master AR address
m_arid  out  4  master AR id
m_arlen  out  8  equals BURST_LEN
m_arsize  out  3  constant 3'b011
m_arburst  out  2  constant 2'b01 (INCR)
m_rvalid  in  1  slave R valid
m_rready  out  1  master R ready
m_rdata  in  64  slave R data
m_rresp  in  2  slave R response
m_rlast  in  1  slave R last
m_rid  in  4  slave R id

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Ports are named clock and rst_n.
- FSM states: IDLE, ADDR, DATA.
- Registers: grant (0=IC, 1=DC), last_grant, latched address.
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=IC, so DCache wins the first tie.
  - All outputs 0, except constant m_arlen/m_arsize/m_arburst.
- IDLE:
  - If exactly one arvalid is high, grant it.
  - If both are high, grant the one that is not last_grant.
  - Latch the granted address and go to ADDR at the next edge.
  - Single-cycle arbitration latency: request at edge N, m_arvalid high after edge N+1.
- ADDR:
  - m_arvalid=1; m_araddr = latched address; m_arid = IC_ID or DC_ID.
  - Granted requester's arready = m_arready (combinational); the other arready = 0.
  - Requesters hold arvalid/araddr stable until arready (AXI rule).
  - On m_arvalid && m_arready: go to DATA; last_grant <= grant.
- DATA:
  - m_rready = granted requester's rready.
  - Granted rvalid = m_rvalid; the other rvalid = 0.
  - rdata/rresp/rlast pass through combinationally from m_r*.
  - On m_rvalid && m_rready && m_rlast: return to IDLE. Arbitration for the next burst starts in that IDLE cycle, so there is one dead cycle between bursts.
- Outside DATA: m_rready=0, ic_rvalid=dc_rvalid=0.
- Routing is by grant register only. m_rid is not used for steering; a beat whose m_rid mismatches the grant is still delivered.
- rresp is forwarded unmodified. The arbiter takes no error action.
- A new arvalid arriving during ADDR/DATA is held pending; it is never accepted mid-burst.
- The non-granted requester may assert/deassert arvalid freely while not granted.
- Reset mid-burst: immediate return to IDLE. Any outstanding slave beats are not consumed; the slave is reset in the same domain.
- No combinational path from ic_arvalid/dc_arvalid to m_arvalid.

Test Plan:
- Reset release, ic_arvalid=1 addr 0x8000_0000, BURST_LEN=1 -> m_arvalid the cycle after the request edge, m_araddr=0x8000_0000, m_arid=0, m_arlen=1, m_arsize=3, m_arburst=1. After 2 beats with rlast on beat 2: ic_rvalid pulses twice, dc_rvalid stays 0, FSM back to IDLE.
- Both arvalid high right after reset (IC 0x8000_0000, DC 0x8000_1000) -> DC granted first (m_arid=1, m_araddr=0x8000_1000); after its rlast, IC granted (m_arid=0); then with both high again, DC wins.
- m_arready held 0 for 5 cycles in ADDR -> m_arvalid/m_araddr stable all 5 cycles; ic_arready=0 until the cycle m_arready=1.
- During a DC burst, toggle ic_rready and hold dc_rready=0 for 3 cycles with m_rvalid=1 -> m_rready=0 those cycles, no beat lost, rdata held by slave; ic_rvalid=0 throughout.
- rst_n pulled low mid-DATA (after beat 1 of 2) -> m_rready, dc_rvalid and m_arvalid drop immediately (asynchronously); after release, a fresh IC request is granted normally.
- m_rresp=2'b10 on the last beat -> rresp=2'b10 with rlast=1 on the granted requester; FSM returns to IDLE normally.
